// File: rtl/pixbuf_pkg.sv
// Shared constants and types for the pixel buffer write arbiter.
package pixbuf_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Pixel word layout: xxxxRRRRGGGGBBBB
  localparam logic [DATA_W-1:0] R_MASK = 16'h0F00;
  localparam logic [DATA_W-1:0] G_MASK = 16'h00F0;
  localparam logic [DATA_W-1:0] B_MASK = 16'h000F;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/pixbuf_rr_arb.sv
// Two-way grant between requesters A and B: fixed A-over-B, or round-robin when
// PIXBUF_WR_ARB_RR_EN is defined.
module pixbuf_rr_arb
  import pixbuf_pkg::*;
(
`ifdef PIXBUF_WR_ARB_RR_EN
  input  logic clk,
  input  logic nrst,
`endif
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_gnt,
  output logic b_gnt
);

`ifdef PIXBUF_WR_ARB_RR_EN
  // ptr_q = 1 means B wins the next contended cycle
  logic ptr_q;

  always_comb begin
    a_gnt = en & a_valid & (~b_valid | ~ptr_q);
    b_gnt = en & b_valid & (~a_valid | ptr_q);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr_q <= 1'b0;
    end else if (a_gnt) begin
      ptr_q <= 1'b1;
    end else if (b_gnt) begin
      ptr_q <= 1'b0;
    end
  end
`else
  always_comb begin
    a_gnt = en & a_valid;
    b_gnt = en & b_valid & ~a_valid;
  end
`endif

endmodule

// File: rtl/pixbuf_wr_arb.sv
// Pixel buffer write-port owner: arbitrates A/B writes and runs a full-buffer clear.
// Define PIXBUF_WR_ARB_RR_EN for round-robin A/B arbitration instead of fixed priority.
module pixbuf_wr_arb
  import pixbuf_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              pb_wr,
  output logic [ADDR_W-1:0] pb_wr_addr,
  output logic [DATA_W-1:0] pb_wr_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic arb_en;
  logic a_gnt, b_gnt;

  // Requesters only compete in IDLE when no clear is being started; nothing is accepted in reset
  assign arb_en = nrst & (state_q == IDLE) & ~clr_start;

  pixbuf_rr_arb u_arb (
`ifdef PIXBUF_WR_ARB_RR_EN
    .clk     (clk),
    .nrst    (nrst),
`endif
    .en      (arb_en),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_gnt   (a_gnt),
    .b_gnt   (b_gnt)
  );

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    wr_d    = 1'b1;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          color_d = clr_color;
          cnt_d   = '0;
          state_d = CLEAR;
          busy_d  = 1'b1;
        end else if (a_gnt) begin
          wr_d   = 1'b0;
          addr_d = a_addr;
          data_d = a_data;
        end else if (b_gnt) begin
          wr_d   = 1'b0;
          addr_d = b_addr;
          data_d = b_data;
        end
      end
      CLEAR: begin
        wr_d   = 1'b0;
        addr_d = cnt_q;
        data_d = color_q;
        if (cnt_q == LAST_ADDR) begin
          // Last write: busy drops and done pulses alongside address DEPTH-1 on pb_*
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + ADDR_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      wr_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pb_wr      = wr_q;
  assign pb_wr_addr = addr_q;
  assign pb_wr_data = data_q;
  assign clr_busy   = busy_q;
  assign clr_done   = done_q;

endmodule
